// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: one-at-a-time byte request sequencer in front of the 4x8 bit-cell RAM.
// Sweeps the array to zero after reset and on demand. Drives registered RAM controls and
// holds the completed response until it is consumed.
module ram_access_ctrl #(
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              clr_req,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_we,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [2:0] S_CLEAR = 3'd0;
  localparam logic [2:0] S_IDLE  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [LAT_W-1:0]  LAST_LAT  = LAT_W'(READ_LAT - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [LAT_W-1:0]  r_lat;
  logic              r_mem_en;
  logic              r_mem_rw;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rsp_valid;
  logic              r_rsp_we;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_busy;

  logic [2:0]        w_state_nxt;
  logic [ADDR_W-1:0] w_cnt_nxt;
  logic [LAT_W-1:0]  w_lat_nxt;
  logic              w_mem_en_nxt;
  logic              w_mem_rw_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [DATA_W-1:0] w_mem_wdata_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_rsp_we_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic              w_busy_nxt;

  assign req_ready = (r_state == S_IDLE) & ~clr_req;
  assign rsp_valid = r_rsp_valid;
  assign rsp_we    = r_rsp_we;
  assign rsp_rdata = r_rsp_rdata;
  assign busy      = r_busy;
  assign mem_en    = r_mem_en;
  assign mem_rw    = r_mem_rw;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // State and registered-output update; reset parks in CLEAR with everything low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_CLEAR;
      r_cnt       <= '0;
      r_lat       <= '0;
      r_mem_en    <= 1'b0;
      r_mem_rw    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_rdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_lat       <= w_lat_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_rw    <= w_mem_rw_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_we    <= w_rsp_we_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  // Next state and next registered outputs; RAM controls idle low unless a state drives them
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_lat_nxt       = r_lat;
    w_mem_en_nxt    = 1'b0;
    w_mem_rw_nxt    = 1'b0;
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = '0;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_we_nxt    = r_rsp_we;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_busy_nxt      = 1'b0;

    case (r_state)
      S_CLEAR: begin
        // Sweep ends the edge after the last address was driven
        if (r_mem_en && (r_mem_addr == LAST_ADDR)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_mem_en_nxt   = 1'b1;
          w_mem_rw_nxt   = 1'b1;
          w_mem_addr_nxt = r_cnt;
          w_busy_nxt     = 1'b1;
          if (r_cnt != LAST_ADDR) begin
            w_cnt_nxt = r_cnt + ADDR_W'(1);
          end
        end
      end

      S_IDLE: begin
        if (clr_req) begin
          w_state_nxt = S_CLEAR;
          w_cnt_nxt   = '0;
        end else if (req_valid) begin
          w_mem_en_nxt    = 1'b1;
          w_mem_rw_nxt    = req_we;
          w_mem_addr_nxt  = req_addr;
          w_mem_wdata_nxt = req_we ? req_wdata : '0;
          w_lat_nxt       = '0;
          w_state_nxt     = req_we ? S_WRITE : S_READ;
        end
      end

      S_WRITE: begin
        w_rsp_valid_nxt = 1'b1;
        w_rsp_we_nxt    = 1'b1;
        w_rsp_rdata_nxt = '0;
        w_state_nxt     = S_RESP;
      end

      S_READ: begin
        if (r_lat == LAST_LAT) begin
          w_rsp_valid_nxt = 1'b1;
          w_rsp_we_nxt    = 1'b0;
          w_rsp_rdata_nxt = mem_rdata;
          w_state_nxt     = S_RESP;
        end else begin
          w_mem_en_nxt   = 1'b1;
          w_mem_addr_nxt = r_mem_addr;
          w_lat_nxt      = r_lat + LAT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_CLEAR;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule
